// File: rtl/pad_mux_switch_ctrl.sv
// Pad mux reconfiguration controller: gates a pad's OE around a select change so
// the pad never drives while its mux is switching. Per-pad state lives in lane slices.

module pad_mux_switch_lane #(
  parameter int SEL_W       = 2,
  parameter int NBIT_PADCFG = 6
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   sel_we_i,
  input  logic                   cfg_we_i,
  input  logic                   oe_clr_i,
  input  logic                   oe_set_i,
  input  logic [SEL_W-1:0]       sel_i,
  input  logic [NBIT_PADCFG-1:0] cfg_i,
  output logic [SEL_W-1:0]       sel_o,
  output logic [NBIT_PADCFG-1:0] cfg_o,
  output logic                   oe_o
);
  logic [SEL_W-1:0]       sel_d, sel_q;
  logic [NBIT_PADCFG-1:0] cfg_d, cfg_q;
  logic                   oe_d, oe_q;

  always_comb begin
    sel_d = sel_we_i ? sel_i : sel_q;
    cfg_d = cfg_we_i ? cfg_i : cfg_q;
    oe_d  = oe_q;
    if (oe_set_i)      oe_d = 1'b1;
    else if (oe_clr_i) oe_d = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sel_q <= '0;
      cfg_q <= '0;
      oe_q  <= 1'b1;
    end else begin
      sel_q <= sel_d;
      cfg_q <= cfg_d;
      oe_q  <= oe_d;
    end
  end

  assign sel_o = sel_q;
  assign cfg_o = cfg_q;
  assign oe_o  = oe_q;
endmodule

module pad_mux_switch_ctrl #(
  parameter int              N_IO        = 48,
  parameter int              SEL_W       = 2,
  parameter int              NBIT_PADCFG = 6,
  parameter int              SETTLE      = 4,
  parameter logic [N_IO-1:0] LOCK_MASK   = N_IO'(7'b110_0001),
  localparam int             PAD_W       = $clog2(N_IO)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic [PAD_W-1:0]              req_pad_i,
  input  logic [SEL_W-1:0]              req_sel_i,
  input  logic [NBIT_PADCFG-1:0]        req_cfg_i,
  output logic                          done_o,
  output logic                          err_o,
  output logic [N_IO*SEL_W-1:0]         pad_sel_o,
  output logic [N_IO*NBIT_PADCFG-1:0]   pad_cfg_o,
  output logic [N_IO-1:0]               oe_gate_o
);
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {IDLE, GATE_WAIT, UNGATE_WAIT} state_t;

  typedef struct packed {
    logic [PAD_W-1:0]       pad;
    logic [SEL_W-1:0]       sel;
    logic [NBIT_PADCFG-1:0] cfg;
  } req_t;

  state_t           state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  req_t             req_d, req_q;
  logic             done_d, done_q, err_d, err_q;

  logic [N_IO-1:0][SEL_W-1:0]       sel_arr;
  logic [N_IO-1:0][NBIT_PADCFG-1:0] cfg_arr;
  logic [N_IO-1:0]                  oe_arr;

  // Shared write bus into the lanes; only the lane matching wr_pad listens.
  logic                   sel_we, cfg_we, oe_clr, oe_set;
  logic [PAD_W-1:0]       wr_pad;
  logic [SEL_W-1:0]       wr_sel;
  logic [NBIT_PADCFG-1:0] wr_cfg;

  logic             in_range, locked, idx_ok;
  logic [SEL_W-1:0] cur_sel;

  assign in_range = {1'b0, req_pad_i} < (PAD_W+1)'(N_IO);
  assign locked   = in_range ? LOCK_MASK[req_pad_i] : 1'b1;
  assign idx_ok   = in_range && !locked;
  assign cur_sel  = in_range ? sel_arr[req_pad_i] : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    sel_we  = 1'b0;
    cfg_we  = 1'b0;
    oe_clr  = 1'b0;
    oe_set  = 1'b0;
    wr_pad  = req_q.pad;
    wr_sel  = req_q.sel;
    wr_cfg  = req_q.cfg;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          if (!idx_ok) begin
            err_d = 1'b1;
          end else if (req_sel_i == cur_sel) begin
            // Select unchanged: the mux is not switching, so no OE gating is needed.
            cfg_we = 1'b1;
            wr_pad = req_pad_i;
            wr_cfg = req_cfg_i;
            done_d = 1'b1;
          end else begin
            oe_clr  = 1'b1;
            wr_pad  = req_pad_i;
            req_d   = '{pad: req_pad_i, sel: req_sel_i, cfg: req_cfg_i};
            cnt_d   = CNT_W'(SETTLE - 1);
            state_d = GATE_WAIT;
          end
        end
      end
      GATE_WAIT: begin
        if (cnt_q == '0) begin
          sel_we  = 1'b1;
          cfg_we  = 1'b1;
          cnt_d   = CNT_W'(SETTLE - 1);
          state_d = UNGATE_WAIT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      UNGATE_WAIT: begin
        if (cnt_q == '0) begin
          oe_set  = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  for (genvar i = 0; i < N_IO; i++) begin : g_lane
    logic hit;
    assign hit = (wr_pad == PAD_W'(i));
    pad_mux_switch_lane #(.SEL_W(SEL_W), .NBIT_PADCFG(NBIT_PADCFG)) u_lane (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .sel_we_i (sel_we && hit),
      .cfg_we_i (cfg_we && hit),
      .oe_clr_i (oe_clr && hit),
      .oe_set_i (oe_set && hit),
      .sel_i    (wr_sel),
      .cfg_i    (wr_cfg),
      .sel_o    (sel_arr[i]),
      .cfg_o    (cfg_arr[i]),
      .oe_o     (oe_arr[i])
    );
  end

  assign req_ready_o = (state_q == IDLE);
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign pad_sel_o   = sel_arr;
  assign pad_cfg_o   = cfg_arr;
  assign oe_gate_o   = oe_arr;
endmodule

// File: tb/tb_pad_mux_switch_ctrl.sv
// Bench for pad_mux_switch_ctrl: directed scenarios plus random traffic against a
// timestamp-based model (pending change lands at accept+SETTLE, completes at accept+2*SETTLE).
module tb_pad_mux_switch_ctrl;
  localparam int N_IO = 48, SEL_W = 2, NCFG = 6, SETTLE = 4;
  localparam logic [N_IO-1:0] LOCK = 48'h61;
  localparam int W = N_IO * NCFG;

  logic clk_i = 1'b0, rst_i = 1'b0;
  logic req_valid_i = 1'b0;
  logic [5:0] req_pad_i = '0;
  logic [SEL_W-1:0] req_sel_i = '0;
  logic [NCFG-1:0] req_cfg_i = '0;
  logic req_ready_o, done_o, err_o;
  logic [N_IO*SEL_W-1:0] pad_sel_o;
  logic [N_IO*NCFG-1:0] pad_cfg_o;
  logic [N_IO-1:0] oe_gate_o;

  pad_mux_switch_ctrl #(.N_IO(N_IO), .SEL_W(SEL_W), .NBIT_PADCFG(NCFG), .SETTLE(SETTLE)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_pad_i(req_pad_i), .req_sel_i(req_sel_i), .req_cfg_i(req_cfg_i),
    .done_o(done_o), .err_o(err_o), .pad_sel_o(pad_sel_o), .pad_cfg_o(pad_cfg_o),
    .oe_gate_o(oe_gate_o));

  always #5 clk_i = ~clk_i;

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Reference model
  logic [N_IO-1:0][SEL_W-1:0] m_sel;
  logic [N_IO-1:0][NCFG-1:0]  m_cfg;
  logic [N_IO-1:0]            m_oe;
  logic m_done, m_err, m_busy;
  int   tcyc, m_t0, m_pad;
  logic [SEL_W-1:0] m_nsel;
  logic [NCFG-1:0]  m_ncfg;

  task automatic model_reset();
    m_sel = '0; m_cfg = '0; m_oe = '1;
    m_done = 0; m_err = 0; m_busy = 0; tcyc = 0;
  endtask

  task automatic model_step();
    int p;
    tcyc++; m_done = 0; m_err = 0;
    p = int'(req_pad_i);
    if (m_busy) begin
      if (tcyc == m_t0 + SETTLE) begin m_sel[m_pad] = m_nsel; m_cfg[m_pad] = m_ncfg; end
      if (tcyc == m_t0 + 2*SETTLE) begin m_oe[m_pad] = 1'b1; m_done = 1; m_busy = 0; end
    end else if (req_valid_i) begin
      if (p >= N_IO || LOCK[p]) m_err = 1;
      else if (req_sel_i == m_sel[p]) begin m_cfg[p] = req_cfg_i; m_done = 1; end
      else begin
        m_busy = 1; m_t0 = tcyc; m_pad = p; m_nsel = req_sel_i; m_ncfg = req_cfg_i;
        m_oe[p] = 1'b0;
      end
    end
  endtask

  // Called at a negedge: drive, step through one posedge, compare, return at next negedge.
  task automatic cyc(input logic v, input int p, input int s, input int c);
    req_valid_i = v; req_pad_i = 6'(p); req_sel_i = SEL_W'(s); req_cfg_i = NCFG'(c);
    chk("ready", W'(req_ready_o), W'(!m_busy));
    @(posedge clk_i);
    model_step();
    #1;
    chk("done", W'(done_o), W'(m_done));
    chk("err", W'(err_o), W'(m_err));
    chk("sel", W'(pad_sel_o), W'(m_sel));
    chk("cfg", pad_cfg_o, m_cfg);
    chk("oe", W'(oe_gate_o), W'(m_oe));
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    #2 rst_i = 1'b1;
    #1;
    chk("rst_ready", W'(req_ready_o), W'(1));
    chk("rst_done", W'(done_o), W'(0));
    chk("rst_err", W'(err_o), W'(0));
    chk("rst_sel", W'(pad_sel_o), W'(0));
    chk("rst_cfg", pad_cfg_o, W'(0));
    chk("rst_oe", W'(oe_gate_o), W'({N_IO{1'b1}}));
    model_reset();
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  initial begin
    int p, s, r;
    model_reset();
    @(negedge clk_i);
    do_reset();

    // Slow path on pad 10, then reset after edge 2
    cyc(1, 10, 1, 3);
    chk("gate10_low", W'(oe_gate_o[10]), W'(0));
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    do_reset();
    chk("rst_oe10", W'(oe_gate_o[10]), W'(1));
    chk("rst_sel10", W'(pad_sel_o[21:20]), W'(0));
    cyc(0, 0, 0, 0);

    // Full slow path on pad 10
    cyc(1, 10, 1, 3);
    for (int i = 1; i <= 2*SETTLE; i++) begin
      cyc(0, 0, 0, 0);
      if (i == SETTLE) begin
        chk("sel10_at_E4", W'(pad_sel_o[21:20]), W'(1));
        chk("cfg10_at_E4", W'(pad_cfg_o[65:60]), W'(3));
        chk("oe10_at_E4", W'(oe_gate_o[10]), W'(0));
      end
    end
    chk("done_at_E8", W'(done_o), W'(1));
    chk("oe10_at_E8", W'(oe_gate_o[10]), W'(1));

    // Fast path three in a row
    for (int i = 0; i < 3; i++) begin
      cyc(1, 12, 0, 'h21 + i);
      chk("fast_done", W'(done_o), W'(1));
    end
    chk("fast_oe", W'(oe_gate_o), W'({N_IO{1'b1}}));

    // Rejects
    cyc(1, 5, 2, 7);
    chk("lock_err", W'(err_o), W'(1));
    cyc(1, 48, 2, 7);
    chk("range_err", W'(err_o), W'(1));
    chk("rej_ready", W'(req_ready_o), W'(1));

    // Second request held valid during a slow path
    cyc(1, 20, 3, 9);
    for (int i = 0; i < 3*SETTLE; i++) cyc(1, 10, 2, 'h15);
    for (int i = 0; i < 2*SETTLE; i++) cyc(0, 0, 0, 0);
    chk("held_sel10", W'(pad_sel_o[21:20]), W'(2));

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
        continue;
      end
      r = $urandom_range(0, 9);
      if (r == 0)      p = ($urandom_range(0, 2) == 0) ? 0 : ($urandom_range(0, 1) ? 5 : 6);
      else if (r == 1) p = 48 + $urandom_range(0, 15);
      else             p = $urandom_range(0, N_IO-1);
      if (p < N_IO && $urandom_range(0, 1)) s = int'(m_sel[p]);
      else s = $urandom_range(0, 3);
      cyc($urandom_range(0, 3) != 0, p, s, $urandom_range(0, 63));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
